// File: rtl/gpr_wb_arbiter_pkg.sv
// gpr_wb_arbiter_pkg: shared constants for the register-file write-back arbiter.
package gpr_wb_arbiter_pkg;
  localparam int REG_COUNT = 32;
  localparam int GPR_DATA_W = 32;
  localparam int NUM_REQ_DEF = 3;
  localparam logic WRITE = 1'b0;
  localparam logic READ = 1'b1;
  typedef enum logic [1:0] {
    REQ_ALU = 2'd0,
    REQ_LSU = 2'd1,
    REQ_CSR = 2'd2
  } req_id_e;
endpackage

// File: rtl/gpr_wb_arbiter_rr_arbiter.sv
// gpr_wb_arbiter_rr_arbiter: round-robin pick starting at ptr_i, one-hot grant gated by en_i.
module gpr_wb_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic found;
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
    if (en_i && found) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: round-robin share of the GPR write port; registered active-low strobe, x0 writes dropped and counted.
module gpr_wb_arbiter
  import gpr_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W = $clog2(REG_COUNT),
  parameter int DATA_W = GPR_DATA_W,
  parameter int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wb_hold,
  output logic                      gpr_we_,
  output logic [ADDR_W-1:0]         gpr_wr_addr,
  output logic [DATA_W-1:0]         gpr_wr_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic [15:0]               drop_cnt
);
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0] win, rr_ptr_q, rr_ptr_d, gid_q, gid_d;
  logic [ADDR_W-1:0] win_addr, addr_q, addr_d;
  logic [DATA_W-1:0] win_data, data_q, data_d;
  logic [15:0] drop_q, drop_d;
  logic we_q, we_d, xfer, drop, wr;
  gpr_wb_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .en_i(!wb_hold),
    .gnt_o(gnt),
    .idx_o(win)
  );
  // ready is masked combinationally so it drops the instant reset asserts
  assign req_ready = reset ? gnt : '0;
  assign xfer = |(req_valid & req_ready);
  assign win_addr = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign win_data = req_data[int'(win)*DATA_W +: DATA_W];
  assign drop = xfer && (win_addr == '0);
  assign wr = xfer && !drop;
  always_comb begin
    rr_ptr_d = xfer ? ((win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1) : rr_ptr_q;
    we_d = wr ? WRITE : READ;
    addr_d = wr ? win_addr : addr_q;
    data_d = wr ? win_data : data_q;
    gid_d = wr ? win : gid_q;
    drop_d = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      we_q <= READ;
      addr_q <= '0;
      data_q <= '0;
      gid_q <= '0;
      drop_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q <= gid_d;
      drop_q <= drop_d;
    end
  end
  assign gpr_we_ = we_q;
  assign gpr_wr_addr = addr_q;
  assign gpr_wr_data = data_q;
  assign grant_id = gid_q;
  assign drop_cnt = drop_q;
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single general-purpose register file write port among several write-back requesters (ALU result, load data, CSR read value).
- Round-robin arbitration with a valid/ready handshake on each requester.
- Produces a registered, one-cycle write strobe toward the register file: active-low write enable, address and data.
- Sits between the execute/memory write-back stages and the register file. Drops writes to x0 so the register file never sees them.

Parameters:
- NUM_REQ, 3, number of write-back requesters; index 0 = ALU, 1 = load, 2 = CSR.
- ADDR_W, 5, register address width; equals $clog2 of register count (32).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_addr  input  NUM_REQ*ADDR_W  flattened destination addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  flattened write data, same packing.
- wb_hold  input  1  blocks all grants this cycle (debug halt / pipeline freeze).
- gpr_we_  output  1  register-file write enable; 0 = WRITE, 1 = READ/idle.
- gpr_wr_addr  output  ADDR_W  register-file write address.
- gpr_wr_data  output  DATA_W  register-file write data.
- grant_id  output  $clog2(NUM_REQ)  index of requester whose write is on the port this cycle.
- drop_cnt  output  16  saturating count of accepted writes to x0.

Behaviour:
- Reset (reset low, async):
  - gpr_we_=1; gpr_wr_addr=0; gpr_wr_data=0; grant_id=0; drop_cnt=0.
  - rr_ptr=0.
  - req_ready forced to all-zero while reset is low.
- Arbitration (combinational, cycle t):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first valid index is the winner.
  - req_ready[winner]=1 only if wb_hold=0; all other ready bits are 0.
  - A transfer occurs when req_valid[i] && req_ready[i].
- Pointer update:
  - On a transfer, rr_ptr <= winner+1, wrapping to 0 at NUM_REQ.
  - With no transfer, rr_ptr holds.
- Output stage (registered, 1-cycle latency):
  - A transfer at cycle t with addr!=0 gives gpr_we_=0, gpr_wr_addr=addr, gpr_wr_data=data and grant_id=winner at cycle t+1, for exactly one cycle.
  - A transfer with addr==0 keeps gpr_we_=1 at t+1 and increments drop_cnt. drop_cnt saturates at 16'hFFFF.
  - No transfer at t: gpr_we_=1 at t+1. Address and data hold their previous values.
- Throughput: one write per cycle. Back-to-back transfers produce consecutive gpr_we_=0 cycles.
- Ordering: writes to the same address from different requesters reach the register file in grant order; the later grant overwrites.
- Requester contract: must hold valid, addr and data stable until accepted. The arbiter never deasserts ready mid-cycle for a stable request.
- wb_hold=1: no ready, no transfer, rr_ptr holds, gpr_we_=1 on the next cycle.
- Reset asserted mid-operation: a pending registered write is discarded (gpr_we_ returns to 1 immediately); un-granted requests are lost from the arbiter's view.

Decomposition:
- Shared define file holds:
  - `WRITE (1'b0) and `READ (1'b1).
  - The register count and data width constants.
  - Requester index constants REQ_ALU=0, REQ_LSU=1, REQ_CSR=2.
- One sub-module: rr_arbiter. Parameterised by NUM_REQ; inputs req vector, pointer and enable; outputs one-hot grant and encoded index. It is reusable for a future memory-port arbiter.

Test Plan:
- Single request: req_valid=3'b001, addr=5, data=32'hDEAD_BEEF -> ready[0]=1 same cycle; next cycle gpr_we_=0, addr=5, data=DEAD_BEEF, grant_id=0; following cycle gpr_we_=1.
- All three valid continuously, with addresses 1, 2, 3 -> grants in order 0,1,2,0,1,2; gpr_we_=0 every cycle from t+1; each requester gets 1 of every 3 cycles.
- x0 drop: requester 2 writes addr=0, data=32'h1234 -> ready[2]=1; gpr_we_ stays 1; drop_cnt goes 0 -> 1.
- Same-address race: req0 addr=7 data=A and req1 addr=7 data=B, both valid at rr_ptr=0 -> A written at t+1, B at t+2; the register file finally holds B.
- wb_hold: all valid with wb_hold=1 for 4 cycles -> req_ready=0, gpr_we_=1, rr_ptr unchanged; after release, grants resume at the prior rr_ptr.
- Async reset mid-write: reset pulled low between clock edges while gpr_we_=0 -> gpr_we_=1, drop_cnt=0 and req_ready=0 immediately without waiting for a clock edge; after release, first grant goes to requester 0.
